// File: rtl/fc_result_collector.sv
// fc_result_collector: gathers the score vector of the final FC layer over
// Depth beats, scans it for the signed argmax (one class per cycle, lower
// index wins ties) and presents the result with a one-cycle strobe.
// Expects NumClasses >= 2, NumClasses divisible by Depth, Timeout >= 1.
module fc_result_collector #(
  parameter int BitSize    = 8,
  parameter int NumClasses = 8,
  parameter int Depth      = 4,
  parameter int Timeout    = 8
) (
  input  logic                                            clk,
  input  logic                                            res,
  input  logic                                            in_valid,
  input  logic [NumClasses/Depth-1:0][BitSize-1:0]        in_data,
  input  logic                                            in_done,
  output logic                                            out_valid,
  output logic [$clog2(NumClasses)-1:0]                   out_class,
  output logic [BitSize-1:0]                              out_max,
  output logic [NumClasses-1:0][BitSize-1:0]              out_scores,
  output logic [15:0]                                     out_frames,
  output logic                                            out_err
);

  localparam int Chunk = NumClasses / Depth;
  localparam int CW    = $clog2(NumClasses);
  localparam int BW    = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int TW    = $clog2(Timeout + 1);

  typedef enum logic [1:0] {IDLE, COLLECT, COMPARE, PRESENT} state_e;

  state_e                              state_q;
  logic [BW-1:0]                       beat_q;
  logic [TW-1:0]                       tmo_q;
  logic [CW-1:0]                       idx_q;
  logic [CW-1:0]                       best_q;
  logic [NumClasses-1:0][BitSize-1:0]  scores_q;

  logic          last_beat;
  logic          in_collect;
  logic          abort;
  logic          cand_wins;
  logic [CW-1:0] best_d;

  assign last_beat  = (beat_q == BW'(Depth - 1));
  assign in_collect = (state_q == COLLECT);
  // A partial vector is dropped on end-of-set (unless this beat completes it)
  // or when the Timeout-th consecutive idle cycle is reached.
  assign abort = in_collect &&
                 ((in_done && !(in_valid && last_beat)) ||
                  (!in_valid && tmo_q == TW'(Timeout - 1)));
  // Strict greater-than keeps the earlier (lower) index on ties.
  assign cand_wins = $signed(scores_q[idx_q]) > $signed(scores_q[best_q]);
  assign best_d    = cand_wins ? idx_q : best_q;

  // Control FSM with registered result outputs.
  always_ff @(posedge clk) begin
    if (res) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      tmo_q      <= '0;
      idx_q      <= '0;
      best_q     <= '0;
      scores_q   <= '0;
      out_valid  <= 1'b0;
      out_class  <= '0;
      out_max    <= '0;
      out_scores <= '0;
      out_frames <= '0;
      out_err    <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state_q)
        IDLE, COLLECT: begin
          if (abort) begin
            beat_q  <= '0;
            tmo_q   <= '0;
            out_err <= 1'b1;
            state_q <= IDLE;
          end else if (in_valid) begin
            for (int j = 0; j < Chunk; j++)
              scores_q[CW'(int'(beat_q) * Chunk + j)] <= in_data[j];
            tmo_q <= '0;
            if (last_beat) begin
              beat_q  <= '0;
              idx_q   <= CW'(1);
              best_q  <= '0;
              state_q <= COMPARE;
            end else begin
              beat_q  <= beat_q + BW'(1);
              state_q <= COLLECT;
            end
          end else if (in_collect) begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        COMPARE: begin
          if (in_valid) out_err <= 1'b1;
          best_q <= best_d;
          idx_q  <= idx_q + CW'(1);
          // The last class is folded in directly so the result lands one
          // cycle earlier than a separate commit stage would allow.
          if (idx_q == CW'(NumClasses - 1)) begin
            out_valid  <= 1'b1;
            out_class  <= best_d;
            out_max    <= scores_q[best_d];
            out_scores <= scores_q;
            out_frames <= out_frames + 16'd1;
            state_q    <= PRESENT;
          end
        end
        PRESENT: begin
          if (in_valid) out_err <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
